// File: rtl/fft_frame_sched.sv
// Two-channel round-robin frame scheduler sharing one FFT core: arbitrates requests,
// reconfigures the core only when N or direction changes, then streams a gap-free frame.
module fft_frame_sched #(
  parameter int   DATA_WIDTH = 16,
  parameter int   MAX_STAGE  = 12,
  parameter logic DEF_IFFT   = 1'b0,
  parameter int   CFG_SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_i,
  input  logic [7:0]                req_n_i,
  input  logic [1:0]                req_ifft_i,
  output logic [1:0]                gnt_o,
  input  logic [1:0]                src_vld_i,
  output logic [1:0]                src_rdy_o,
  input  logic [2*DATA_WIDTH-1:0]   src_real_i,
  input  logic [2*DATA_WIDTH-1:0]   src_imag_i,
  output logic [1:0]                done_o,
  output logic [1:0]                err_o,
  input  logic                      core_ready_i,
  output logic                      core_cfg_vld_o,
  output logic                      core_cfg_ifft_o,
  output logic [3:0]                core_cfg_n_o,
  output logic                      core_start_o,
  output logic                      core_vld_o,
  output logic [DATA_WIDTH-1:0]     core_real_o,
  output logic [DATA_WIDTH-1:0]     core_imag_o
);

  localparam int         CW    = MAX_STAGE + 1;
  localparam int         SW    = (CFG_SETTLE > 1) ? $clog2(CFG_SETTLE) : 1;
  localparam logic [3:0] MAX_N = 4'(MAX_STAGE);
  localparam logic [3:0] MIN_N = 4'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_CFG    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]    state_reg;
  logic          last_reg;
  logic          gsel_reg;
  logic [3:0]    sel_n_reg;
  logic          sel_ifft_reg;
  logic [3:0]    cache_n_reg;
  logic          cache_ifft_reg;
  logic [SW-1:0] settle_cnt_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    blocked_reg;
  logic [3:0]    bad_n_reg [2];

  logic [3:0]            ch_n    [2];
  logic [DATA_WIDTH-1:0] ch_real [2];
  logic [DATA_WIDTH-1:0] ch_imag [2];
  logic [1:0]            eligible;
  logic [1:0]            fresh_bad;

  // A channel with an illegal N reports once, then stays quiet until its N changes.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      assign ch_n[gi]      = req_n_i[gi*4 +: 4];
      assign ch_real[gi]   = src_real_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ch_imag[gi]   = src_imag_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign eligible[gi]  = req_i[gi] && (ch_n[gi] >= MIN_N) && (ch_n[gi] <= MAX_N);
      assign fresh_bad[gi] = req_i[gi] && !((ch_n[gi] >= MIN_N) && (ch_n[gi] <= MAX_N)) &&
                             !(blocked_reg[gi] && (ch_n[gi] == bad_n_reg[gi]));
    end
  endgenerate

  logic          win;
  logic          any_elig;
  logic [CW:0]   frame_len;
  logic [CW-1:0] last_idx;

  assign any_elig  = |eligible;
  assign win       = (eligible == 2'b11) ? ~last_reg : eligible[1];
  assign frame_len = (CW+1)'(1) << sel_n_reg;
  assign last_idx  = CW'(frame_len - (CW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      last_reg        <= 1'b1;
      gsel_reg        <= 1'b0;
      sel_n_reg       <= '0;
      sel_ifft_reg    <= 1'b0;
      cache_n_reg     <= MAX_N;
      cache_ifft_reg  <= DEF_IFFT;
      settle_cnt_reg  <= '0;
      cnt_reg         <= '0;
      blocked_reg     <= '0;
      for (int c = 0; c < 2; c++) bad_n_reg[c] <= '0;
      gnt_o           <= '0;
      src_rdy_o       <= '0;
      done_o          <= '0;
      err_o           <= '0;
      core_cfg_vld_o  <= 1'b0;
      core_cfg_ifft_o <= 1'b0;
      core_cfg_n_o    <= '0;
      core_start_o    <= 1'b0;
      core_vld_o      <= 1'b0;
      core_real_o     <= '0;
      core_imag_o     <= '0;
    end else begin
      core_cfg_vld_o <= 1'b0;
      core_start_o   <= 1'b0;
      core_vld_o     <= 1'b0;
      core_real_o    <= '0;
      core_imag_o    <= '0;
      done_o         <= '0;
      err_o          <= '0;
      for (int c = 0; c < 2; c++) begin
        if (blocked_reg[c] && (ch_n[c] != bad_n_reg[c])) blocked_reg[c] <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (|req_i) state_reg <= S_ARB;
        end
        S_ARB: begin
          for (int c = 0; c < 2; c++) begin
            if (fresh_bad[c]) begin
              err_o[c]       <= 1'b1;
              blocked_reg[c] <= 1'b1;
              bad_n_reg[c]   <= ch_n[c];
            end
          end
          if (any_elig) begin
            gnt_o        <= win ? 2'b10 : 2'b01;
            gsel_reg     <= win;
            sel_n_reg    <= ch_n[win];
            sel_ifft_reg <= req_ifft_i[win];
            if ((ch_n[win] == cache_n_reg) && (req_ifft_i[win] == cache_ifft_reg))
              state_reg <= S_WAIT;
            else
              state_reg <= S_CFG;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_CFG: begin
          core_cfg_vld_o  <= 1'b1;
          core_cfg_n_o    <= sel_n_reg;
          core_cfg_ifft_o <= sel_ifft_reg;
          cache_n_reg     <= sel_n_reg;
          cache_ifft_reg  <= sel_ifft_reg;
          settle_cnt_reg  <= SW'(CFG_SETTLE - 1);
          state_reg       <= (CFG_SETTLE == 0) ? S_WAIT : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_reg == '0) state_reg <= S_WAIT;
          else settle_cnt_reg <= settle_cnt_reg - SW'(1);
        end
        S_WAIT: begin
          if (core_ready_i) begin
            state_reg <= S_STREAM;
            cnt_reg   <= '0;
            src_rdy_o <= gsel_reg ? 2'b10 : 2'b01;
          end
        end
        S_STREAM: begin
          // The core cannot tolerate gaps, so a missing sample becomes zero plus an error.
          core_vld_o   <= 1'b1;
          core_start_o <= (cnt_reg == '0);
          if (src_vld_i[gsel_reg]) begin
            core_real_o <= ch_real[gsel_reg];
            core_imag_o <= ch_imag[gsel_reg];
          end else begin
            err_o[gsel_reg] <= 1'b1;
          end
          if (cnt_reg == last_idx) begin
            cnt_reg   <= '0;
            src_rdy_o <= '0;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_DONE: begin
          done_o[gsel_reg] <= 1'b1;
          gnt_o            <= '0;
          last_reg         <= gsel_reg;
          state_reg        <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: a source model pushes expected core samples into a
// scoreboard queue as they are offered, and the monitor pops and compares them on core_vld_o.
module tb_fft_frame_sched;

  localparam int DW         = 16;
  localparam int MAX_STAGE  = 12;
  localparam int CFG_SETTLE = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [7:0]      req_n;
  logic [1:0]      req_ifft;
  logic [1:0]      gnt_o;
  logic [1:0]      src_vld;
  logic [1:0]      src_rdy_o;
  logic [2*DW-1:0] src_real;
  logic [2*DW-1:0] src_imag;
  logic [1:0]      done_o;
  logic [1:0]      err_o;
  logic            core_ready;
  logic            core_cfg_vld_o;
  logic            core_cfg_ifft_o;
  logic [3:0]      core_cfg_n_o;
  logic            core_start_o;
  logic            core_vld_o;
  logic [DW-1:0]   core_real_o;
  logic [DW-1:0]   core_imag_o;

  always #5 clk = ~clk;

  fft_frame_sched #(
    .DATA_WIDTH (DW),
    .MAX_STAGE  (MAX_STAGE),
    .DEF_IFFT   (1'b0),
    .CFG_SETTLE (CFG_SETTLE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .req_n_i         (req_n),
    .req_ifft_i      (req_ifft),
    .gnt_o           (gnt_o),
    .src_vld_i       (src_vld),
    .src_rdy_o       (src_rdy_o),
    .src_real_i      (src_real),
    .src_imag_i      (src_imag),
    .done_o          (done_o),
    .err_o           (err_o),
    .core_ready_i    (core_ready),
    .core_cfg_vld_o  (core_cfg_vld_o),
    .core_cfg_ifft_o (core_cfg_ifft_o),
    .core_cfg_n_o    (core_cfg_n_o),
    .core_start_o    (core_start_o),
    .core_vld_o      (core_vld_o),
    .core_real_o     (core_real_o),
    .core_imag_o     (core_imag_o)
  );

  typedef struct packed {
    logic          start;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } samp_t;

  samp_t      sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         tick_no  = 0;
  int         vld_cnt, start_cnt, cfg_cnt, gnt_tick, cfg_tick;
  int         err_cnt[2];
  int         done_cnt[2];
  int         frames_left[2];
  int         src_idx[2];
  int         drop_a, drop_b;
  int         gnt_log[$];
  int         start_log[$];
  logic [1:0] gnt_prev;
  logic [3:0] last_cfg_n;
  logic       last_cfg_ifft;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    vld_cnt = 0; start_cnt = 0; cfg_cnt = 0; gnt_tick = -1; cfg_tick = -1;
    for (int c = 0; c < 2; c++) begin err_cnt[c] = 0; done_cnt[c] = 0; end
    gnt_log.delete();
    start_log.delete();
    last_cfg_n = '0; last_cfg_ifft = 1'b0;
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({gnt_o, src_rdy_o, done_o, err_o, core_cfg_vld_o, core_cfg_ifft_o, core_cfg_n_o,
                core_start_o, core_vld_o, core_real_o, core_imag_o});
  endfunction

  // One clock: monitor outputs at the falling edge, then drive the source for the next rising edge.
  task automatic tick();
    samp_t         e;
    samp_t         n;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          v;
    @(negedge clk);
    tick_no++;
    chk("gnt_onehot", 64'(gnt_o & (gnt_o - 2'd1)), 64'd0);
    if (core_vld_o) begin
      vld_cnt++;
      if (core_start_o) begin start_cnt++; start_log.push_back(tick_no); end
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sample", 64'({core_start_o, core_real_o, core_imag_o}), 64'(e));
      end
    end
    if (core_cfg_vld_o) begin
      cfg_cnt++; cfg_tick = tick_no; last_cfg_n = core_cfg_n_o; last_cfg_ifft = core_cfg_ifft_o;
    end
    if (gnt_o != 2'b00 && gnt_o != gnt_prev) begin gnt_log.push_back(int'(gnt_o[1])); gnt_tick = tick_no; end
    gnt_prev = gnt_o;
    for (int c = 0; c < 2; c++) begin
      if (err_o[c]) err_cnt[c]++;
      if (done_o[c]) begin
        done_cnt[c]++;
        if (frames_left[c] > 0) frames_left[c]--;
        if (frames_left[c] == 0) req[c] = 1'b0;
      end
      re = DW'($urandom);
      im = DW'($urandom);
      src_real[c*DW +: DW] = re;
      src_imag[c*DW +: DW] = im;
      if (src_rdy_o[c]) begin
        v = !(src_idx[c] == drop_a || src_idx[c] == drop_b);
        src_vld[c] = v;
        n.start = (src_idx[c] == 0);
        n.re    = v ? re : '0;
        n.im    = v ? im : '0;
        sb_q.push_back(n);
        src_idx[c]++;
      end else begin
        src_vld[c] = 1'b1;
        src_idx[c] = 0;
      end
    end
  endtask

  task automatic wait_done(input int c, input int budget, input string tag);
    int target;
    int t;
    target = done_cnt[c] + 1;
    t = 0;
    while (done_cnt[c] < target && t < budget) begin tick(); t++; end
    chk(tag, 64'(done_cnt[c] >= target), 64'd1);
  endtask

  initial begin
    int t0;
    int ready_tick;
    int t;
    int code;
    rst_n = 1'b0; req = '0; req_n = '0; req_ifft = '0; src_vld = '0;
    src_real = '0; src_imag = '0; core_ready = 1'b0;
    drop_a = -1; drop_b = -1; gnt_prev = '0;
    for (int c = 0; c < 2; c++) begin frames_left[c] = 0; src_idx[c] = 0; end
    clear_tally();
    repeat (3) tick();
    chk("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: ch0 N=12 FFT matches the reset cache; latency req->gnt 2, gnt->first sample 2.
    clear_tally();
    core_ready = 1'b1;
    req_n[3:0] = 4'd12; req_ifft[0] = 1'b0; frames_left[0] = 1;
    t0 = tick_no; req[0] = 1'b1;
    wait_done(0, 6000, "t1_done_seen");
    repeat (3) tick();
    chk("t1_gnt_latency", 64'(gnt_tick - t0), 64'd2);
    chk("t1_vld_latency", 64'(((start_log.size() > 0) ? start_log[0] : -1000) - gnt_tick), 64'd2);
    chk("t1_cfg_cnt", 64'(cfg_cnt), 64'd0);
    chk("t1_vld_cnt", 64'(vld_cnt), 64'd4096);
    chk("t1_start_cnt", 64'(start_cnt), 64'd1);
    chk("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
    chk("t1_err_cnt", 64'(err_cnt[0] + err_cnt[1]), 64'd0);
    chk("t1_sb_empty", 64'(sb_q.size()), 64'd0);

    // 2: ch0 N=12 FFT then ch1 N=10 IFFT; core not ready after reconfiguration.
    clear_tally();
    req_n = {4'd10, 4'd12}; req_ifft = 2'b10;
    frames_left[0] = 1; frames_left[1] = 1;
    req[0] = 1'b1;
    t = 0;
    while (start_cnt < 1 && t < 20) begin tick(); t++; end
    core_ready = 1'b0;
    req[1] = 1'b1;
    wait_done(0, 5000, "t2_ch0_done_seen");
    t = 0;
    while (cfg_cnt < 1 && t < 20) begin tick(); t++; end
    repeat (10) tick();
    chk("t2_held_by_ready", 64'(start_cnt), 64'd1);
    chk("t2_gnt_ch1", 64'(gnt_o), 64'd2);
    ready_tick = tick_no; core_ready = 1'b1;
    wait_done(1, 2000, "t2_ch1_done_seen");
    repeat (3) tick();
    chk("t2_cfg_cnt", 64'(cfg_cnt), 64'd1);
    chk("t2_cfg_n", 64'(last_cfg_n), 64'd10);
    chk("t2_cfg_ifft", 64'(last_cfg_ifft), 64'd1);
    chk("t2_ready_to_start", 64'(((start_log.size() > 1) ? start_log[1] : -1000) - ready_tick), 64'd2);
    chk("t2_vld_cnt", 64'(vld_cnt), 64'd5120);
    code = (gnt_log.size() == 2) ? (gnt_log[0] + 2 * gnt_log[1]) : 99;
    chk("t2_gnt_order", 64'(code), 64'd2);
    chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3: both channels, two frames each at N=4 -> grants 0,1,0,1 back to back.
    clear_tally();
    req_n = {4'd4, 4'd4}; req_ifft = 2'b00;
    frames_left[0] = 2; frames_left[1] = 2;
    req = 2'b11;
    t = 0;
    while ((done_cnt[0] < 2 || done_cnt[1] < 2) && t < 400) begin tick(); t++; end
    repeat (3) tick();
    code = 0;
    for (int i = 0; i < gnt_log.size() && i < 4; i++) code = code + (gnt_log[i] << i);
    chk("t3_gnt_count", 64'(gnt_log.size()), 64'd4);
    chk("t3_gnt_order", 64'(code), 64'd10);
    chk("t3_cfg_cnt", 64'(cfg_cnt), 64'd1);
    chk("t3_settle", 64'(((start_log.size() > 0) ? start_log[0] : -1000) - cfg_tick), 64'(CFG_SETTLE + 2));
    chk("t3_frame_gap", 64'((start_log.size() > 1) ? (start_log[1] - start_log[0]) : -1), 64'd20);
    chk("t3_vld_cnt", 64'(vld_cnt), 64'd64);

    // 4: ch0 N=3 with samples 2 and 5 missing -> zero-filled, two underrun pulses.
    clear_tally();
    req_n[3:0] = 4'd3; req_ifft[0] = 1'b0; drop_a = 2; drop_b = 5;
    frames_left[0] = 1; req[0] = 1'b1;
    wait_done(0, 100, "t4_done_seen");
    repeat (3) tick();
    drop_a = -1; drop_b = -1;
    chk("t4_vld_cnt", 64'(vld_cnt), 64'd8);
    chk("t4_err0_cnt", 64'(err_cnt[0]), 64'd2);
    chk("t4_err1_cnt", 64'(err_cnt[1]), 64'd0);
    chk("t4_cfg_n", 64'(last_cfg_n), 64'd3);
    chk("t4_sb_empty", 64'(sb_q.size()), 64'd0);

    // 5: ch1 N=13 is illegal -> one error, ch0 served, ch1 never granted.
    clear_tally();
    req_n = {4'd13, 4'd4}; req_ifft = 2'b00;
    frames_left[0] = 1; frames_left[1] = 1;
    req = 2'b11;
    wait_done(0, 200, "t5_done_seen");
    repeat (20) tick();
    chk("t5_err1_cnt", 64'(err_cnt[1]), 64'd1);
    chk("t5_err0_cnt", 64'(err_cnt[0]), 64'd0);
    code = (gnt_log.size() == 1) ? gnt_log[0] : 99;
    chk("t5_gnt_only_ch0", 64'(code), 64'd0);
    chk("t5_done1_cnt", 64'(done_cnt[1]), 64'd0);
    req = 2'b00; frames_left[1] = 0;
    repeat (3) tick();

    // 6: async reset in the middle of an N=10 frame; next N=12 frame reuses the default cache.
    clear_tally();
    req_n[3:0] = 4'd10; frames_left[0] = 1; req[0] = 1'b1;
    t = 0;
    while (vld_cnt < 500 && t < 1200) begin tick(); t++; end
    chk("t6_reached_500", 64'(vld_cnt), 64'd500);
    #2 rst_n = 1'b0;
    #1 chk("t6_reset_outputs", all_outputs(), 64'd0);
    req = '0; frames_left[0] = 0;
    repeat (2) tick();
    sb_q.delete();
    clear_tally();
    rst_n = 1'b1;
    tick();
    req_n[3:0] = 4'd12; frames_left[0] = 1; req[0] = 1'b1;
    wait_done(0, 6000, "t6_done_seen");
    repeat (3) tick();
    chk("t6_cfg_cnt", 64'(cfg_cnt), 64'd0);
    chk("t6_vld_cnt", 64'(vld_cnt), 64'd4096);
    chk("t6_done_cnt", 64'(done_cnt[0]), 64'd1);
    chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
